div_rem_signed: RTL

- Front-end for the pipelined unsigned divide/remainder unit.
- Takes RISC-V M-extension DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed overflow locally.
- Converts signed operands to magnitudes, issues them to the unsigned unit, then restores the result sign.
- Uses the same order/accepted/done handshake upstream (core) and downstream (unsigned unit).

---
 rtl/div_rem_signed.sv | 111 +++++++++++
 1 files changed

// File: rtl/div_rem_signed.sv
// Signed front-end for the unsigned divide/remainder unit: RISC-V DIV/DIVU/REM/REMU.
// Optional macro DIVREM_SHORTCUT_EN finishes |rs1| < |rs2| locally without ordering the unit.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module div_rem_signed #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         order,
    output logic         accepted,
    output logic         done,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    input  logic [1:0]   funct,
    output logic [W-1:0] rd,
    output logic         u_order,
    input  logic         u_accepted,
    input  logic         u_done,
    output logic [W-1:0] u_rs1,
    output logic [W-1:0] u_rs2,
    output logic         u_rem_flag,
    input  logic [W-1:0] u_rd
);

    if (W != `LEN_WORD) begin : g_bad_width
        $error("div_rem_signed: W must equal LEN_WORD");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t       state, state_nxt;
    logic         rem_q, neg_q, neg_r;
    logic [W-1:0] res_q;

    logic         sgn, rem_in;
    logic [W-1:0] mag1, mag2;
    logic         div0, ovf, short_cut, quick;
    logic [W-1:0] quick_res;

    always_comb begin
        sgn    = ~funct[0];
        rem_in = funct[1];
        mag1   = (sgn & rs1[W-1]) ? -rs1 : rs1;
        mag2   = (sgn & rs2[W-1]) ? -rs2 : rs2;
        div0   = (rs2 == '0);
        ovf    = sgn && (rs1 == {1'b1, {(W-1){1'b0}}}) && (rs2 == '1);
`ifdef DIVREM_SHORTCUT_EN
        short_cut = (mag1 < mag2);
`else
        short_cut = 1'b0;
`endif
        quick = div0 | ovf | short_cut;
        // Priority: divide-by-zero, then overflow, then |rs1| < |rs2|.
        if (div0)
            quick_res = rem_in ? rs1 : '1;
        else if (ovf)
            quick_res = rem_in ? '0 : {1'b1, {(W-1){1'b0}}};
        else
            quick_res = rem_in ? rs1 : '0;
    end

    assign accepted   = order & (state == IDLE);
    assign done       = (state == FIN);
    assign rd         = done ? res_q : '0;
    assign u_order    = (state == ISSUE);
    assign u_rem_flag = u_order & rem_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (order) state_nxt = quick ? FIN : ISSUE;
            ISSUE: if (u_accepted) state_nxt = WAIT;
            WAIT:  if (u_done) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            u_rs1 <= '0;
            u_rs2 <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (accepted) begin
                rem_q <= rem_in;
                neg_q <= sgn & (rs1[W-1] ^ rs2[W-1]);
                neg_r <= sgn & rs1[W-1];
                u_rs1 <= mag1;
                u_rs2 <= mag2;
                if (quick) res_q <= quick_res;
            end
            // Remainder follows the dividend's sign; quotient follows the sign product.
            if (state == WAIT && u_done) begin
                if (rem_q ? neg_r : neg_q)
                    res_q <= -u_rd;
                else
                    res_q <= u_rd;
            end
        end
    end

endmodule
